// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and the blocks that sit in front of it.
package fifo_pkg;

    // Default beat width; the FIFO and its write-side arbiter must agree on it.
    localparam int FIFO_DATAWIDTH = 8;

    // Write-arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        REL  = 2'd2
    } arb_state_t;

    // Increment an index and wrap it back to zero at the modulus.
    function automatic int wrap_inc(input int value, input int modulus);
        int result;
        if ((value + 32'sd1) >= modulus) begin
            result = 32'sd0;
        end else begin
            result = value + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first set request scanning upward
// from ptr with wrap-around. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDXW-1:0] idx
);

    logic found_s;
    int   pos_s;

    // Scan NREQ positions starting at ptr and keep the first requester found.
    always_comb begin
        sel     = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = 32'sd0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = int'(ptr) + k;
            if (pos_s >= NREQ) begin
                pos_s = pos_s - NREQ;
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s]) begin
                found_s    = 1'b1;
                sel[pos_s] = 1'b1;
                idx        = IDXW'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NREQ
// requesters. A grant covers a whole packet (or up to MAXBURST beats),
// every beat is gated by f_full, and a one-cycle REL gap separates bursts.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = FIFO_DATAWIDTH,
    parameter int MAXBURST  = 16,
    parameter int CNTW      = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           last,
    input  logic [NREQ*DATAWIDTH-1:0] din,
    input  logic                      f_full,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic                      wr_en,
    output logic [DATAWIDTH-1:0]      data_out
);

    localparam int OWNW = $clog2(NREQ);

    arb_state_t          state_r, state_s;
    logic [NREQ-1:0]     gnt_r, gnt_s;
    logic [OWNW-1:0]     owner_r, owner_s;
    logic [OWNW-1:0]     ptr_r, ptr_s;
    logic [CNTW-1:0]     cnt_r, cnt_s;
    logic                busy_r, busy_s;

    logic [NREQ-1:0]     pick_sel_s;
    logic [OWNW-1:0]     pick_idx_s;
    logic                owner_req_s;
    logic                owner_last_s;
    logic                wr_en_s;
    logic                release_s;
    logic [NREQ-1:0]     ack_s;
    logic [DATAWIDTH-1:0] data_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (OWNW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_r),
        .sel (pick_sel_s),
        .idx (pick_idx_s)
    );

    assign owner_req_s  = req[owner_r];
    assign owner_last_s = last[owner_r];

    // Beat gating: only the owner may write, only in XFER, never while full.
    always_comb begin
        wr_en_s = 1'b0;
        ack_s   = '0;
        if (state_r == XFER) begin
            wr_en_s = owner_req_s & ~f_full;
        end else begin
            wr_en_s = 1'b0;
        end
        if (wr_en_s) begin
            ack_s = gnt_r;
        end else begin
            ack_s = '0;
        end
    end

    // Select the owner's data lane for the FIFO data input.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_r == OWNW'(i)) begin
                data_s = din[i*DATAWIDTH +: DATAWIDTH];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting and release in XFER.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = XFER;
                    gnt_s   = pick_sel_s;
                    owner_s = pick_idx_s;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (!owner_req_s) begin
                    // Owner withdrew mid-packet: abort without writing.
                    release_s = 1'b1;
                end else if (wr_en_s) begin
                    if (owner_last_s || ((cnt_r + CNTW'(1)) == CNTW'(MAXBURST))) begin
                        release_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNTW'(1);
                    end
                end else begin
                    // Stalled on f_full: grant and count are frozen.
                    cnt_s = cnt_r;
                end
                if (release_s) begin
                    state_s = REL;
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                    ptr_s   = OWNW'(wrap_inc(int'(owner_r), NREQ));
                end else begin
                    state_s = XFER;
                end
            end
            REL: begin
                state_s = IDLE;
                gnt_s   = '0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                gnt_s   = '0;
                busy_s  = 1'b0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and grant registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
        end
    end

    assign gnt      = gnt_r;
    assign owner    = owner_r;
    assign busy     = busy_r;
    assign wr_en    = wr_en_s;
    assign ack      = ack_s;
    assign data_out = data_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requesters are modelled as queues of beats and
// the expected write stream / grant order is derived at packet level.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 16;
    localparam int CNTW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  last;
    logic [NREQ*DW-1:0] din;
    logic             f_full;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  gnt;
    logic [1:0]       owner;
    logic             busy;
    logic             wr_en;
    logic [DW-1:0]    data_out;

    int total = 0;
    int bad   = 0;

    logic [8:0] bq [NREQ][$];      // per requester {last, data}
    logic [9:0] exp_w[$];          // expected writes {owner, data}
    logic [9:0] obs_w[$];
    int         exp_g[$];
    int         obs_g[$];
    int         obs_gc[$];         // cycle of each grant
    int         obs_wc[$];         // cycle of each write
    logic [3:0] gnt_log[$];
    logic       wr_log[$];
    logic       busy_log[$];

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DATAWIDTH (DW),
        .MAXBURST  (MAXB),
        .CNTW      (CNTW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .din      (din),
        .f_full   (f_full),
        .ack      (ack),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .wr_en    (wr_en),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst    = 1'b0;
        req    = '0;
        last   = '0;
        din    = '0;
        f_full = 1'b0;
        for (int i = 0; i < NREQ; i++) bq[i].delete();
        exp_w.delete(); obs_w.delete(); exp_g.delete(); obs_g.delete();
        obs_gc.delete(); obs_wc.delete();
        gnt_log.delete(); wr_log.delete(); busy_log.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_packet(input int r, input int len, input bit with_last);
        logic [8:0] b;
        for (int k = 0; k < len; k++) begin
            b[7:0] = 8'($urandom_range(0, 255));
            b[8]   = with_last && (k == len - 1);
            bq[r].push_back(b);
        end
    endtask

    // Packet-level reference: round-robin over non-empty queues; a burst runs
    // until a last beat, MAXB beats, or the requester runs out of data.
    task automatic build_model();
        int pos[NREQ];
        int p;
        int o;
        int n;
        int c;
        logic [8:0] b;
        logic [1:0] ov;
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        p = 0;
        forever begin
            o = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (p + k) % NREQ;
                if (o < 0 && pos[c] < bq[c].size()) o = c;
            end
            if (o < 0) break;
            exp_g.push_back(o);
            ov = o[1:0];
            n = 0;
            while (pos[o] < bq[o].size()) begin
                b = bq[o][pos[o]];
                pos[o]++;
                n++;
                exp_w.push_back({ov, b[7:0]});
                if (b[8] || n == MAXB) break;
            end
            p = (o + 1) % NREQ;
        end
    endtask

    // Drive requesters from their queues cycle by cycle and record outputs.
    task automatic run(input int budget, input bit partial, input int fmode,
                       input int flo, input int fhi);
        logic [3:0] prev_gnt;
        logic [3:0] exp_ack;
        logic       exp_wr;
        bit         done;
        bit         empty;
        int         cyc;
        prev_gnt = '0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bq[i].size() > 0) begin
                    req[i] = 1'b1;
                    din[i*DW +: DW] = bq[i][0][7:0];
                    last[i] = bq[i][0][8];
                end else begin
                    req[i] = 1'b0;
                    din[i*DW +: DW] = 8'($urandom_range(0, 255));
                    last[i] = 1'($urandom_range(0, 1));
                end
            end
            case (fmode)
                1: f_full = ($urandom_range(0, 3) == 0);
                2: f_full = (cyc >= flo && cyc <= fhi);
                default: f_full = 1'b0;
            endcase
            #1;
            total++;
            if (f_full && wr_en) begin
                bad++;
                $display("FAIL write_while_full: cycle %0d wr_en=%0b required 0", cyc, wr_en);
            end
            exp_ack = wr_en ? (4'b0001 << owner) : 4'b0000;
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL ack_onehot: cycle %0d got %b expected %b", cyc, ack, exp_ack);
            end
            exp_wr = ((gnt & req) != 4'b0000) && !f_full;
            total++;
            if (wr_en !== exp_wr) begin
                bad++;
                $display("FAIL wr_en_gate: cycle %0d got %b expected %b", cyc, wr_en, exp_wr);
            end
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                obs_g.push_back(int'(owner));
                obs_gc.push_back(cyc);
                total++;
                if (gnt !== (4'b0001 << owner)) begin
                    bad++;
                    $display("FAIL gnt_owner: cycle %0d gnt=%b owner=%0d", cyc, gnt, owner);
                end
            end
            gnt_log.push_back(gnt);
            wr_log.push_back(wr_en);
            busy_log.push_back(busy);
            if (wr_en === 1'b1) begin
                obs_w.push_back({owner, data_out});
                obs_wc.push_back(cyc);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] === 1'b1 && bq[i].size() > 0) void'(bq[i].pop_front());
            end
            prev_gnt = gnt;
            cyc++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (bq[i].size() > 0) empty = 1'b0;
            if (empty && busy === 1'b0 && gnt === 4'b0000) done = 1'b1;
        end
        if (!partial) begin
            total++;
            if (!done) begin
                bad++;
                $display("FAIL drain_timeout: ran %0d cycles, queues not drained", cyc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; last = 4'b1111; din = $urandom; f_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_priority: got %b expected 0001", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy: got %b expected 1", busy); end
        total++; if (data_out !== din[7:0]) begin bad++; $display("FAIL first_data: got %h expected %h", data_out, din[7:0]); end
        apply_reset();
    endtask

    task automatic test_single_packet();
        logic [8:0] b;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            b = {(k == 3), 8'(8'h11 + k)};
            bq[0].push_back(b);
        end
        build_model();
        run(100, 1'b0, 0, 0, 0);
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL single_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL single_data[%0d]: got %h expected %h", k, obs_w[k], exp_w[k]); end
        end
        total++; if (obs_gc.size() < 1 || obs_gc[0] != 1) begin bad++; $display("FAIL single_latency: got grant cycle %0d expected 1", obs_gc.size() > 0 ? obs_gc[0] : -1); end
        total++;
        if (wr_log.size() < 6 || wr_log[0] !== 1'b0 || wr_log[1] !== 1'b1 || wr_log[4] !== 1'b1 || wr_log[5] !== 1'b0) begin
            bad++; $display("FAIL single_wr_window: got %0d log entries, expected writes on cycles 1..4 only", wr_log.size());
        end
        total++;
        if (gnt_log.size() < 6 || gnt_log[5] !== 4'b0000 || busy_log[5] !== 1'b0) begin
            bad++; $display("FAIL single_rel: REL cycle not idle (entries=%0d)", gnt_log.size());
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        push_packet(0, 2, 1'b1);
        push_packet(0, 2, 1'b1);
        for (int r = 1; r < NREQ; r++) push_packet(r, 2, 1'b1);
        build_model();
        run(200, 1'b0, 0, 0, 0);
        total++; if (obs_g.size() != exp_g.size()) begin bad++; $display("FAIL rr_grants: got %0d expected %0d", obs_g.size(), exp_g.size()); end
        for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
            total++; if (obs_g[k] != exp_g[k]) begin bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, obs_g[k], exp_g[k]); end
        end
        for (int k = 1; k < obs_gc.size(); k++) begin
            total++; if (obs_gc[k] - obs_gc[k-1] != 4) begin bad++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", k, obs_gc[k] - obs_gc[k-1]); end
        end
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL rr_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL rr_data[%0d]: got %h expected %h", k, obs_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        push_packet(2, 6, 1'b1);
        build_model();
        run(100, 1'b0, 2, 3, 7);
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL stall_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL stall_data[%0d]: got %h expected %h", k, obs_w[k], exp_w[k]); end
        end
        for (int c = 3; c <= 7; c++) begin
            total++;
            if (gnt_log.size() <= c || gnt_log[c] !== 4'b0100 || wr_log[c] !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d]: grant not held or write during full", c);
            end
        end
        total++; if (obs_wc.size() < 3 || obs_wc[2] != 8) begin bad++; $display("FAIL stall_resume: got cycle %0d expected 8", obs_wc.size() > 2 ? obs_wc[2] : -1); end
    endtask

    task automatic test_maxburst();
        int first_n;
        apply_reset();
        push_packet(1, 20, 1'b0);
        build_model();
        run(200, 1'b0, 0, 0, 0);
        total++; if (obs_g.size() != 2 || exp_g.size() != 2) begin bad++; $display("FAIL maxb_grants: got %0d expected 2", obs_g.size()); end
        for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
            total++; if (obs_g[k] != exp_g[k]) begin bad++; $display("FAIL maxb_owner[%0d]: got %0d expected %0d", k, obs_g[k], exp_g[k]); end
        end
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL maxb_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL maxb_data[%0d]: got %h expected %h", k, obs_w[k], exp_w[k]); end
        end
        first_n = 0;
        if (obs_gc.size() > 1) begin
            for (int k = 0; k < obs_wc.size(); k++) if (obs_wc[k] < obs_gc[1]) first_n++;
        end
        total++; if (first_n != MAXB) begin bad++; $display("FAIL maxb_first_burst: got %0d writes expected %0d", first_n, MAXB); end
        total++; if (obs_gc.size() < 2 || obs_gc[1] != 19) begin bad++; $display("FAIL maxb_regrant: got cycle %0d expected 19", obs_gc.size() > 1 ? obs_gc[1] : -1); end
    endtask

    task automatic test_abort();
        apply_reset();
        push_packet(0, 3, 1'b0);
        push_packet(3, 2, 1'b1);
        build_model();
        run(100, 1'b0, 0, 0, 0);
        total++; if (obs_g.size() != exp_g.size()) begin bad++; $display("FAIL abort_grants: got %0d expected %0d", obs_g.size(), exp_g.size()); end
        for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
            total++; if (obs_g[k] != exp_g[k]) begin bad++; $display("FAIL abort_order[%0d]: got %0d expected %0d", k, obs_g[k], exp_g[k]); end
        end
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL abort_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL abort_data[%0d]: got %h expected %h", k, obs_w[k], exp_w[k]); end
        end
        total++;
        if (wr_log.size() < 5 || wr_log[4] !== 1'b0 || busy_log[4] !== 1'b1 || gnt_log[4] !== 4'b0001) begin
            bad++; $display("FAIL abort_cycle: expected busy owner 0 with no write on cycle 4");
        end
        total++; if (obs_gc.size() < 2 || obs_wc.size() < 3 || obs_gc[1] != obs_wc[2] + 4) begin bad++; $display("FAIL abort_regrant: got cycle %0d expected 7", obs_gc.size() > 1 ? obs_gc[1] : -1); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_packet(0, 2, 1'b1);
        push_packet(1, 10, 1'b1);
        run(7, 1'b1, 0, 0, 0);
        total++; if (busy_log.size() != 7 || busy_log[6] !== 1'b1 || gnt_log[6] !== 4'b0010) begin bad++; $display("FAIL areset_setup: requester 1 not mid-burst before reset"); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL areset_gnt: got %b expected 0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL areset_wr_en: got %b expected 0", wr_en); end
        apply_reset();
        push_packet(0, 2, 1'b1);
        push_packet(2, 2, 1'b1);
        build_model();
        run(100, 1'b0, 0, 0, 0);
        total++; if (obs_g.size() < 1 || obs_g[0] != 0) begin bad++; $display("FAIL areset_first_grant: got %0d expected 0", obs_g.size() > 0 ? obs_g[0] : -1); end
        for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
            total++; if (obs_g[k] != exp_g[k]) begin bad++; $display("FAIL areset_order[%0d]: got %0d expected %0d", k, obs_g[k], exp_g[k]); end
        end
    endtask

    task automatic test_random();
        int npk;
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            for (int r = 0; r < NREQ; r++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) push_packet(r, $urandom_range(1, 20), ($urandom_range(0, 3) != 0));
            end
            build_model();
            run(3000, 1'b0, 1, 0, 0);
            total++; if (obs_g.size() != exp_g.size()) begin bad++; $display("FAIL rand%0d_grants: got %0d expected %0d", it, obs_g.size(), exp_g.size()); end
            for (int k = 0; k < exp_g.size() && k < obs_g.size(); k++) begin
                total++; if (obs_g[k] != exp_g[k]) begin bad++; $display("FAIL rand%0d_order[%0d]: got %0d expected %0d", it, k, obs_g[k], exp_g[k]); end
            end
            total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_w.size(), exp_w.size()); end
            for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
                total++; if (obs_w[k] !== exp_w[k]) begin bad++; $display("FAIL rand%0d_data[%0d]: got %h expected %h", it, k, obs_w[k], exp_w[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_maxburst();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
